// File: rtl/serial_adder_pkg.sv
// Shared types and sizing helpers for the digit-serial adder.
// Used by serial_adder and its testbench.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    function automatic int num_steps(input int width, input int digit);
        return width / digit;
    endfunction

    // The step counter needs at least one bit, even when there is a single step.
    function automatic int cnt_width(input int width, input int digit);
        int n;
        n = width / digit;
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/digit_adder.sv
// Combinational DIGIT-bit ripple adder with carry in and carry out.
module digit_adder #(
    parameter int DIGIT = 8
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             ci,
    output logic [DIGIT-1:0] s,
    output logic             co
);

    assign {co, s} = {1'b0, x} + {1'b0, y} + {{DIGIT{1'b0}}, ci};

endmodule

// File: rtl/serial_adder.sv
// Digit-serial adder: WIDTH-bit a + b + cin, DIGIT bits per clock, valid/ready on both sides.
// Optional SERIAL_ADDER_SUB_EN adds a 'sub' port computing a - b (cout=1 means no borrow).
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIGIT = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int N  = num_steps(WIDTH, DIGIT);
    localparam int CW = cnt_width(WIDTH, DIGIT);

    generate
        if ((WIDTH % DIGIT) != 0) begin : g_bad_digit
            $fatal(1, "serial_adder: WIDTH must be a multiple of DIGIT");
        end
    endgenerate

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;

    logic [DIGIT-1:0] digit_sum;
    logic             digit_co;
    logic [WIDTH-1:0] b_load;
    logic             carry_load;

    digit_adder #(
        .DIGIT(DIGIT)
    ) u_digit_adder (
        .x (a_q[DIGIT-1:0]),
        .y (b_q[DIGIT-1:0]),
        .ci(carry_q),
        .s (digit_sum),
        .co(digit_co)
    );

    // Subtraction is folded into the load: invert b and force the initial carry.
`ifdef SERIAL_ADDER_SUB_EN
    assign b_load     = sub ? ~b : b;
    assign carry_load = sub ? 1'b1 : cin;
`else
    assign b_load     = b;
    assign carry_load = cin;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b_load;
                    carry_d = carry_load;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                carry_d = digit_co;
                cout_d  = digit_co;
                // New digit enters at the top so the LSB digit ends up at bit 0.
                sum_d   = (sum_q >> DIGIT) | (WIDTH'(digit_sum) << (WIDTH - DIGIT));
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;

endmodule
